fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000; PC loaded on reset.
REQ-002 The block SHALL have parameter IBUF_DEPTH, default 4; instruction buffer entries, power of two, 2..16.
REQ-003 The block SHALL have input clk, 1 bit; the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have input reset, 1 bit; synchronous, active-high.
REQ-005 The block SHALL have output imem_req_valid_o, 1 bit; instruction-memory read request valid.
REQ-006 The block SHALL have output imem_req_addr_o, 32 bits; request word address (byte address, [1:0]=0).
REQ-007 The block SHALL have input imem_req_ready_i, 1 bit; memory accepts the request this cycle.
REQ-008 The block SHALL have input imem_rsp_valid_i, 1 bit; response valid; responses return in request order, latency >=1 cycle.
REQ-009 The block SHALL have input imem_rsp_data_i, 32 bits; returned instruction word.
REQ-010 The block SHALL have input redirect_valid_i, 1 bit; flush and restart fetch (branch/jump resolve).
REQ-011 The block SHALL have input redirect_pc_i, 32 bits; new fetch PC.
REQ-012 The block SHALL have output dec_valid_o, 1 bit; instruction available to decode.
REQ-013 The block SHALL have output dec_inst_o, 32 bits; instruction word to decode.
REQ-014 The block SHALL have output dec_pc_o, 32 bits; PC of dec_inst_o.
REQ-015 The block SHALL have input dec_ready_i, 1 bit; decode consumes the head entry this cycle.

Function
REQ-016 A request handshake SHALL occur when imem_req_valid_o && imem_req_ready_i, and the fetch PC SHALL then advance by 4, wrapping modulo 2^32.
REQ-017 imem_req_valid_o SHALL be 1 only when outstanding_count + ibuf_count < IBUF_DEPTH (credit rule), so the buffer never overflows.
REQ-018 Each request's PC SHALL be held in an in-order tag FIFO of depth IBUF_DEPTH and paired with its response on arrival.
REQ-019 An accepted (non-discarded) response SHALL be written to the instruction buffer {inst, pc} in the same cycle it arrives, with no bypass: dec_valid_o rises one cycle after the response.
REQ-020 A decode handshake SHALL occur when dec_valid_o && dec_ready_i and SHALL pop the head; dec_inst_o and dec_pc_o SHALL be held stable while dec_valid_o=1 and dec_ready_i=0.
REQ-021 dec_valid_o SHALL equal (ibuf_count != 0).
REQ-022 A simultaneous push and pop SHALL leave ibuf_count unchanged; pop from an empty buffer SHALL be impossible and push to a full buffer SHALL be prevented by REQ-017.
REQ-023 A simultaneous request handshake and response SHALL leave outstanding_count unchanged.
REQ-024 The block SHALL have state machine states RUN and DRAIN.
REQ-025 On redirect_valid_i in any state, the block SHALL: flush the instruction buffer (dec_valid_o=0 next cycle); set fetch PC := redirect_pc_i; set discard_count := outstanding requests, including any request handshaking in the redirect cycle; and go to DRAIN if discard_count>0, otherwise RUN.
REQ-026 In the redirect cycle itself, imem_req_valid_o MAY be 1 for the old PC, but that request SHALL be counted for discard; a response arriving in the redirect cycle SHALL be discarded.
REQ-027 In DRAIN, each response SHALL be dropped and decrement discard_count; new requests from the redirected PC SHALL be allowed under REQ-017; the state SHALL move to RUN when the last stale response is dropped.
REQ-028 A redirect in DRAIN SHALL add the newly outstanding requests to discard_count.
REQ-029 A redirect SHALL take priority over a decode handshake in the same cycle; the popped entry is lost.
REQ-030 The request address imem_req_addr_o SHALL equal the fetch PC, and SHALL be held stable while imem_req_valid_o=1 and imem_req_ready_i=0, unless a redirect occurs.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL set: fetch PC=RESET_PC; state=RUN; all counts=0; both FIFOs empty.
REQ-032 After reset, the outputs SHALL be: imem_req_valid_o=0 in the reset cycle and 1 from the first cycle after reset; dec_valid_o=0; dec_inst_o=0; dec_pc_o=0.
REQ-033 Reset asserted mid-operation SHALL abandon all in-flight requests; the memory is reset alongside the block.

Configuration
REQ-034 When macro FETCH_STATS_EN is defined, the block SHALL add output fetch_count_o (32 bits), counting decode handshakes, with the counter cleared by reset and wrapping.
REQ-035 When macro FETCH_STATS_EN is undefined, the port and the counter SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-036 Reset release with RESET_PC=0x100, ready=1 and 1-cycle memory -> the bench SHALL see requests 0x100, 0x104, 0x108, ...; dec_pc_o=0x100 two cycles after the first request.
REQ-037 dec_ready_i=0 held, IBUF_DEPTH=4 -> the bench SHALL see exactly 4 requests, then imem_req_valid_o=0; after dec_ready_i=1, one new request per pop.
REQ-038 Redirect to 0x200 with 2 requests outstanding -> the bench SHALL see the next 2 responses dropped and first dec_pc_o=0x200; dec_valid_o=0 in the cycle after the redirect.
REQ-039 imem_req_ready_i=0 for 5 cycles -> the bench SHALL see imem_req_addr_o stable at the same value and no advance of PC.
REQ-040 Push and pop in the same cycle at count=2 -> the bench SHALL see the count stay at 2 and outputs in order with no loss; with FETCH_STATS_EN, fetch_count_o equal to the number of pops.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order PC tag FIFO and instruction buffer.
// Optional FETCH_STATS_EN macro adds fetch_count_o, a wrapping count of decode handshakes.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        dec_valid_o,
  output logic [31:0] dec_inst_o,
  output logic [31:0] dec_pc_o,
  input  logic        dec_ready_i
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count_o
`endif
);

  localparam int AW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = IBUF_DEPTH[CW:0];

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding, outstanding_nx;
  logic [CW-1:0] discard, discard_nx;
  logic [CW-1:0] ib_count;
  logic [AW-1:0] tag_wr, tag_rd, ib_head, ib_tail;
  logic [31:0]   tag_pc  [IBUF_DEPTH];
  logic [31:0]   ib_inst [IBUF_DEPTH];
  logic [31:0]   ib_pc   [IBUF_DEPTH];
  logic [CW:0]   credit_sum;
  logic          req_fire, rsp_fire, push, pop;

  // Outstanding requests plus buffered words may never exceed the buffer size.
  assign credit_sum       = {1'b0, outstanding} + {1'b0, ib_count};
  assign imem_req_valid_o = !reset && (credit_sum < DEPTH_C);
  assign imem_req_addr_o  = fetch_pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign rsp_fire         = imem_rsp_valid_i && (outstanding != '0);

  // Responses are only kept in RUN; a redirect kills both the arriving word and any pop.
  assign push = rsp_fire && !redirect_valid_i && (state == RUN);
  assign dec_valid_o = (ib_count != '0);
  assign pop  = dec_valid_o && dec_ready_i && !redirect_valid_i;
  assign dec_inst_o = dec_valid_o ? ib_inst[ib_head] : '0;
  assign dec_pc_o   = dec_valid_o ? ib_pc[ib_head]   : '0;

  assign outstanding_nx = outstanding + CW'(req_fire) - CW'(rsp_fire);

  always_comb begin
    state_nx   = state;
    discard_nx = discard;
    if (redirect_valid_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      discard_nx = outstanding_nx;
      state_nx   = (outstanding_nx != '0) ? DRAIN : RUN;
    end else if (state == DRAIN && rsp_fire) begin
      discard_nx = discard - CW'(1);
      if (discard == CW'(1)) state_nx = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      ib_head     <= '0;
      ib_tail     <= '0;
      ib_count    <= '0;
    end else begin
      state       <= state_nx;
      discard     <= discard_nx;
      outstanding <= outstanding_nx;
      if (req_fire) tag_wr <= tag_wr + AW'(1);
      if (rsp_fire) tag_rd <= tag_rd + AW'(1);
      if (redirect_valid_i)
        fetch_pc <= redirect_pc_i;
      else if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;
      if (redirect_valid_i) begin
        ib_head  <= '0;
        ib_tail  <= '0;
        ib_count <= '0;
      end else begin
        if (push) ib_tail <= ib_tail + AW'(1);
        if (pop)  ib_head <= ib_head + AW'(1);
        ib_count <= ib_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and counts above.
  always_ff @(posedge clk) begin
    if (req_fire) tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      ib_inst[ib_tail] <= imem_rsp_data_i;
      ib_pc[ib_tail]   <= tag_pc[tag_rd];
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      fetch_count_o <= '0;
    else if (dec_valid_o && dec_ready_i)
      fetch_count_o <= fetch_count_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model checked every cycle, plus directed literal checks.
module tb_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        dec_valid_o;
  logic [31:0] dec_inst_o;
  logic [31:0] dec_pc_o;
  logic        dec_ready_i;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_o;
`endif

  fetch_unit #(.RESET_PC(RPC), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i),
    .dec_valid_o(dec_valid_o),
    .dec_inst_o(dec_inst_o),
    .dec_pc_o(dec_pc_o),
    .dec_ready_i(dec_ready_i)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count_o(fetch_count_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory environment: answers each accepted request after lat cycles, in order.
  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t mq[$];
  int    lat = 1;
  int    cyc = 0;
  int    req_cnt = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
  end

  // Reference model: fetch PC, in-flight PCs (oldest first, m_stale of them doomed), buffered words.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t        m_ib[$];
  logic [31:0] m_out[$];
  int          m_stale = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_hs_cnt = '0;
  bit          m_init = 1'b0;

  always @(negedge clk) begin
    bit          exp_req, hs, pop, do_push;
    logic [31:0] p;
    ent_t        pe;
    exp_req = !reset && (m_out.size() + m_ib.size() < DEPTH);
    if (m_init) begin
      check("req_valid", imem_req_valid_o, exp_req);
      check("req_addr", imem_req_addr_o, m_pc);
      check("dec_valid", dec_valid_o, m_ib.size() != 0);
      if (m_ib.size() != 0) begin
        check("dec_inst", dec_inst_o, m_ib[0].inst);
        check("dec_pc", dec_pc_o, m_ib[0].pc);
      end else begin
        check("dec_inst_idle", dec_inst_o, 32'h0);
        check("dec_pc_idle", dec_pc_o, 32'h0);
      end
`ifdef FETCH_STATS_EN
      check("fetch_count", fetch_count_o, m_hs_cnt);
`endif
    end
    if (!reset && imem_req_valid_o && imem_req_ready_i) begin
      mq.push_back('{due: cyc + lat, addr: imem_req_addr_o});
      req_cnt++;
    end
    if (reset) begin
      mq.delete();
      m_ib.delete();
      m_out.delete();
      m_stale  = 0;
      m_pc     = RPC;
      m_hs_cnt = '0;
      m_init   = 1'b1;
    end else if (m_init) begin
      hs      = exp_req && imem_req_ready_i;
      pop     = !redirect_valid_i && dec_ready_i && (m_ib.size() != 0);
      do_push = 1'b0;
      pe      = '0;
      if (dec_ready_i && m_ib.size() != 0) m_hs_cnt = m_hs_cnt + 32'd1;
      if (imem_rsp_valid_i) begin
        check("rsp_expected", m_out.size() != 0, 1'b1);
        if (m_out.size() != 0) begin
          p = m_out.pop_front();
          if (m_stale > 0) m_stale--;
          else if (!redirect_valid_i) begin
            do_push = 1'b1;
            pe = '{inst: mem_word(p), pc: p};
          end
        end
      end
      if (redirect_valid_i) m_ib.delete();
      else begin
        if (pop) void'(m_ib.pop_front());
        if (do_push) m_ib.push_back(pe);
      end
      if (hs) m_out.push_back(m_pc);
      if (redirect_valid_i) begin
        m_stale = m_out.size();
        m_pc    = redirect_pc_i;
      end else if (hs) m_pc = m_pc + 32'd4;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles; returns at the start of the first cycle after reset.
  task automatic do_reset(input int l);
    reset = 1'b1;
    redirect_valid_i = 1'b0;
    lat = l;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1;
    imem_req_ready_i = 1'b1;
    dec_ready_i = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    tick();
    tick();
    #1;
    check("rst_req_valid", imem_req_valid_o, 1'b0);
    check("rst_dec_valid", dec_valid_o, 1'b0);
    check("rst_dec_inst", dec_inst_o, 32'h0);
    check("rst_dec_pc", dec_pc_o, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("first_req_valid", imem_req_valid_o, 1'b1);
    check("first_req_addr", imem_req_addr_o, 32'h100);
    tick(); #1;
    check("second_req_addr", imem_req_addr_o, 32'h104);
    check("no_bypass", dec_valid_o, 1'b0);
    tick(); #1;
    check("first_dec_valid", dec_valid_o, 1'b1);
    check("first_dec_pc", dec_pc_o, 32'h100);
    check("first_dec_inst", dec_inst_o, mem_word(32'h100));
    check("third_req_addr", imem_req_addr_o, 32'h108);
    repeat (8) tick();

    // Decode stalled: credits allow exactly DEPTH requests, then one per pop.
    dec_ready_i = 1'b0;
    do_reset(1);
    base = req_cnt;
    repeat (10) tick();
    #1;
    check("stall_req_count", req_cnt - base, 4);
    check("stall_req_valid", imem_req_valid_o, 1'b0);
    check("stall_head_pc", dec_pc_o, 32'h100);
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
    #1;
    check("credit_back_valid", imem_req_valid_o, 1'b1);
    check("credit_back_addr", imem_req_addr_o, 32'h110);
    check("credit_back_head", dec_pc_o, 32'h104);
    tick(); #1;
    check("credit_used_valid", imem_req_valid_o, 1'b0);
    check("credit_req_count", req_cnt - base, 5);

    // Steady push+pop with two entries buffered.
    dec_ready_i = 1'b0;
    do_reset(1);
    tick();
    tick();
    tick();
    dec_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("pushpop_valid", dec_valid_o, 1'b1);
      check("pushpop_pc", dec_pc_o, 32'h100 + 32'(4 * k));
      if (k < 3) tick();
    end
`ifdef FETCH_STATS_EN
    check("pushpop_count", fetch_count_o, 32'd3);
`endif
    repeat (3) tick();

    // Memory not ready for five cycles: address holds.
    imem_req_ready_i = 1'b0;
    dec_ready_i = 1'b1;
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("hold_addr", imem_req_addr_o, 32'h100);
      check("hold_valid", imem_req_valid_o, 1'b1);
      tick();
    end
    imem_req_ready_i = 1'b1;
    #1;
    check("hold_release_addr", imem_req_addr_o, 32'h100);
    tick(); #1;
    check("hold_advance_addr", imem_req_addr_o, 32'h104);

    // Redirect with two requests in flight, 3-cycle memory.
    imem_req_ready_i = 1'b1;
    do_reset(3);
    tick();
    tick();
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h200;
    tick();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    #1;
    check("redir_dec_valid", dec_valid_o, 1'b0);
    check("redir_addr", imem_req_addr_o, 32'h200);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      check("drain_dec_valid", dec_valid_o, 1'b0);
    end
    tick(); #1;
    check("redir_first_valid", dec_valid_o, 1'b1);
    check("redir_first_pc", dec_pc_o, 32'h200);
    check("redir_first_inst", dec_inst_o, mem_word(32'h200));

    // Second redirect while still draining.
    do_reset(3);
    tick();
    tick();
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h200;
    tick();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h300;
    tick();
    redirect_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("redrain_dec_valid", dec_valid_o, 1'b0);
      tick();
    end
    #1;
    check("redrain_first_valid", dec_valid_o, 1'b1);
    check("redrain_first_pc", dec_pc_o, 32'h300);

    // Mixed back-pressure, stalls and redirects (one near the top of the address space).
    imem_req_ready_i = 1'b1;
    dec_ready_i = 1'b1;
    do_reset(1);
    for (int i = 0; i < 80; i++) begin
      lat = (i < 40) ? 1 : 2;
      imem_req_ready_i = (i % 5 != 4);
      dec_ready_i = (i % 3 != 0);
      redirect_valid_i = (i % 13 == 7);
      redirect_pc_i = (i == 33) ? 32'hFFFF_FFF8 : 32'h400 + 32'(i * 64);
      tick();
    end
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    dec_ready_i = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
